// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the wait-stated memory responder.
// Optional alignment trap: define MEM_RESPONDER_ALIGN_CHECK_EN.
package mem_responder_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  // True when a full word starting at a fits below depth (no wrap).
  function automatic logic addr_in_range(
    input logic [31:0] a,
    input int unsigned depth
  );
    return a <= 32'(depth - 4);
  endfunction

endpackage

// File: rtl/mem_resp_byte_ram.sv
// Four byte lanes with one synchronous read/write port.
// Any byte address is legal; lane k always holds bytes with addr%4 == k.
module mem_resp_byte_ram
  import mem_responder_pkg::*;
#(
  parameter int    DEPTH_BYTES = 256,
  parameter string INIT_FILE   = "",
  parameter int    AW          = $clog2(DEPTH_BYTES)
) (
  input  logic              clock,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [7:0]    mem   [DEPTH_BYTES];
  logic [7:0]    rlane [4];
  logic [7:0]    wlane [4];
  logic [1:0]    off   [4];
  logic [AW-1:0] ba    [4];
  logic [1:0]    rot_q;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      off[k]   = 2'(k) - addr[1:0];
      ba[k]    = addr + AW'(off[k]);
      wlane[k] = wdata[8*off[k] +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (en) begin
      rot_q <= addr[1:0];
      for (int k = 0; k < 4; k++) begin
        if (we) mem[ba[k]] <= wlane[k];
        rlane[k] <= mem[ba[k]];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rdata[8*i +: 8] = rlane[2'(rot_q + 2'(i))];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: wait states, one-cycle Ready, range/align trap.
// Optional alignment trap: define MEM_RESPONDER_ALIGN_CHECK_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int    DEPTH_BYTES = 256,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Req,
  input  logic              Wr,
  input  logic [31:0]       Address,
  input  logic [WORD_W-1:0] DataIn,
  output logic [WORD_W-1:0] DataOut,
  output logic              Ready,
  output logic              AddrErr,
  output logic              Busy
);

  localparam int AW = $clog2(DEPTH_BYTES);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              wr_q;
  logic [AW-1:0]     addr_q;
  logic [WORD_W-1:0] din_q;
  logic [WORD_W-1:0] hold_q;

  logic              req_err;
  logic              go_now;
  logic              go_late;
  logic              ram_en;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata;
  logic [WORD_W-1:0] resp_word;

  always_comb begin
    req_err = !addr_in_range(Address, DEPTH_BYTES);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    if (Address[1:0] != 2'b00) req_err = 1'b1;
`endif
  end

  // The single RAM access happens on the edge that enters RESP.
  assign go_now  = (state == IDLE) && Req && !req_err
                 && (WAIT_STATES == 0);
  assign go_late = (state == WAIT) && (cnt == '0);
  assign ram_en  = reset && (go_now || go_late);

  always_comb begin
    if (state == IDLE) begin
      ram_we    = Wr;
      ram_addr  = Address[AW-1:0];
      ram_wdata = DataIn;
    end else begin
      ram_we    = wr_q;
      ram_addr  = addr_q;
      ram_wdata = din_q;
    end
  end

  mem_resp_byte_ram #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .INIT_FILE   (INIT_FILE),
    .AW          (AW)
  ) u_ram (
    .clock (clock),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Writes echo the written word rather than the pre-write RAM read.
  assign resp_word = wr_q ? din_q : ram_rdata;
  assign DataOut   = (state == RESP) ? resp_word : hold_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      hold_q  <= '0;
      Ready   <= 1'b0;
      AddrErr <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      Ready   <= 1'b0;
      AddrErr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Req) begin
            wr_q   <= Wr;
            addr_q <= Address[AW-1:0];
            din_q  <= DataIn;
            Busy   <= 1'b1;
            if (req_err) begin
              state   <= ERR;
              Ready   <= 1'b1;
              AddrErr <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_STATES - 1);
            end else begin
              state <= RESP;
              Ready <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
            Ready <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          hold_q <= resp_word;
          state  <= IDLE;
          Busy   <= 1'b0;
        end
        ERR: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (0/1/3 wait states).
// Byte-level reference model, directed cases then random traffic.
module tb_mem_responder;

  logic        clock;
  logic        reset;
  logic [2:0]  req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout [3];
  logic [2:0]  rdy;
  logic [2:0]  aerr;
  logic [2:0]  busy;

  int checks;
  int errors;

  int          wsv [3] = '{0, 1, 3};
  logic [7:0]  mem_m [3][256];
  logic [31:0] last [3];

  mem_responder #(.DEPTH_BYTES(256), .WAIT_STATES(0)) u_ws0 (
    .clock(clock), .reset(reset), .Req(req[0]), .Wr(wr),
    .Address(addr), .DataIn(din), .DataOut(dout[0]),
    .Ready(rdy[0]), .AddrErr(aerr[0]), .Busy(busy[0]));

  mem_responder #(.DEPTH_BYTES(256), .WAIT_STATES(1)) u_ws1 (
    .clock(clock), .reset(reset), .Req(req[1]), .Wr(wr),
    .Address(addr), .DataIn(din), .DataOut(dout[1]),
    .Ready(rdy[1]), .AddrErr(aerr[1]), .Busy(busy[1]));

  mem_responder #(.DEPTH_BYTES(256), .WAIT_STATES(3)) u_ws3 (
    .clock(clock), .reset(reset), .Req(req[2]), .Wr(wr),
    .Address(addr), .DataIn(din), .DataOut(dout[2]),
    .Ready(rdy[2]), .AddrErr(aerr[2]), .Busy(busy[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mword(int d, logic [31:0] a);
    return {mem_m[d][a+3], mem_m[d][a+2], mem_m[d][a+1], mem_m[d][a]};
  endfunction

  function automatic bit is_err(logic [31:0] a);
    bit e;
    e = (a > 32'd252);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic txn(int d, bit w, logic [31:0] a, logic [31:0] data);
    bit          e;
    int          exp_lat;
    int          lat;
    logic [31:0] exp_d;
    e       = is_err(a);
    exp_lat = e ? 1 : wsv[d] + 1;
    if (e)      exp_d = last[d];
    else if (w) exp_d = data;
    else        exp_d = mword(d, a);
    @(negedge clock);
    wr = w; addr = a; din = data; req[d] = 1'b1;
    @(posedge clock); #1;
    req[d] = 1'b0;
    addr = $urandom; din = $urandom; wr = 1'($urandom);
    lat = 1;
    while (rdy[d] !== 1'b1 && lat < 40) begin
      chk($sformatf("d%0d busy_wait", d), 32'(busy[d]), 32'd1);
      @(posedge clock); #1;
      lat++;
    end
    chk($sformatf("d%0d ready", d), 32'(rdy[d]), 32'd1);
    chk($sformatf("d%0d latency a=%h", d, a), lat, exp_lat);
    chk($sformatf("d%0d addrerr a=%h", d, a), 32'(aerr[d]), 32'(e));
    chk($sformatf("d%0d busy_resp", d), 32'(busy[d]), 32'd1);
    chk($sformatf("d%0d dout a=%h", d, a), dout[d], exp_d);
    if (!e && w)
      for (int i = 0; i < 4; i++) mem_m[d][a+i] = data[8*i +: 8];
    last[d] = exp_d;
    @(posedge clock); #1;
    chk($sformatf("d%0d one_pulse", d), 32'(rdy[d]), 32'd0);
    chk($sformatf("d%0d idle", d), 32'(busy[d]), 32'd0);
    chk($sformatf("d%0d hold", d), dout[d], exp_d);
  endtask

  initial begin
    logic [31:0] a1;
    logic [31:0] a3;
    logic [31:0] exp_w;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    req = '0; wr = 1'b0; addr = '0; din = '0;
    for (int d = 0; d < 3; d++) last[d] = '0;
    #3;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d rst_ready", d), 32'(rdy[d]), 32'd0);
      chk($sformatf("d%0d rst_err", d), 32'(aerr[d]), 32'd0);
      chk($sformatf("d%0d rst_busy", d), 32'(busy[d]), 32'd0);
      chk($sformatf("d%0d rst_dout", d), dout[d], 32'd0);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Fill every word so the model is fully known.
    for (int d = 0; d < 3; d++)
      for (int a = 0; a <= 252; a += 4)
        txn(d, 1'b1, 32'(a), $urandom);

    txn(1, 1'b1, 32'h10, 32'hDEADBEEF);
    txn(1, 1'b0, 32'h10, 32'h0);
    txn(1, 1'b0, 32'h11, 32'h0);
    txn(0, 1'b1, 32'h40, 32'h01234567);
    txn(2, 1'b1, 32'h40, 32'h89ABCDEF);
    txn(0, 1'b0, 32'h42, 32'h0);
    txn(2, 1'b0, 32'h43, 32'h0);

    txn(1, 1'b1, 32'hFD, 32'h12345678);
    txn(1, 1'b0, 32'hFC, 32'h0);
    txn(0, 1'b0, 32'hFC, 32'h0);
    txn(2, 1'b1, 32'hFFFFFFFF, 32'h55AA55AA);
    txn(0, 1'b0, 32'h100, 32'h0);
    txn(1, 1'b0, 32'h21, 32'h0);

    // Req held high: only the first address is serviced per pass.
    a1 = 32'h30; a3 = 32'h50;
    @(negedge clock);
    wr = 1'b0; addr = a1; req[1] = 1'b1;
    @(posedge clock); #1;
    addr = 32'h60;
    chk("hold_busy_wait", 32'(busy[1]), 32'd1);
    chk("hold_no_ready", 32'(rdy[1]), 32'd0);
    @(posedge clock); #1;
    chk("hold_ready1", 32'(rdy[1]), 32'd1);
    chk("hold_data1", dout[1], mword(1, a1));
    addr = a3;
    @(posedge clock); #1;
    chk("hold_bubble_busy", 32'(busy[1]), 32'd0);
    chk("hold_bubble_ready", 32'(rdy[1]), 32'd0);
    @(posedge clock); #1;
    chk("hold_reaccept", 32'(busy[1]), 32'd1);
    req[1] = 1'b0;
    addr = 32'h70;
    @(posedge clock); #1;
    chk("hold_ready2", 32'(rdy[1]), 32'd1);
    exp_w = mword(1, a3);
    chk("hold_data2", dout[1], exp_w);
    last[1] = exp_w;
    @(posedge clock); #1;
    chk("hold_end", 32'(busy[1]), 32'd0);

    // Reset during WAIT aborts the write.
    @(negedge clock);
    wr = 1'b1; addr = 32'h20; din = 32'hCAFEF00D; req[1] = 1'b1;
    @(posedge clock); #1;
    req[1] = 1'b0;
    chk("abort_in_wait", 32'(busy[1]), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_ready", 32'(rdy[1]), 32'd0);
    chk("abort_err", 32'(aerr[1]), 32'd0);
    chk("abort_busy", 32'(busy[1]), 32'd0);
    chk("abort_dout", dout[1], 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int d = 0; d < 3; d++) last[d] = '0;
    txn(1, 1'b0, 32'h20, 32'h0);

    for (int n = 0; n < 80; n++) begin
      int          d;
      logic [31:0] ra;
      d  = int'($urandom_range(0, 2));
      ra = ($urandom_range(0, 9) == 0) ? $urandom
                                        : 32'($urandom_range(0, 259));
      txn(d, 1'($urandom), ra, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
